awgn_channel: RTL
=================

# awgn_channel

Synthetic channel stage placed between `raised_transmitter` and `raised_receiver`. It takes modulated 16-bit signed samples and adds scaled pseudo-random noise from an LFSR, with saturating arithmetic. Samples pass through a stallable delay pipeline so the receiver sees realistic propagation latency. Clipped samples are counted. With noise disabled, the stage is a transparent fixed-latency delay, so end-to-end encoder/decoder tests run unchanged.

## Interface

Parameters:
- `DELAY`, default 3: pipeline depth in cycles (legal range 1–8).
- `NOISE_SHIFT`, default 4: arithmetic right shift applied to the raw LFSR value to form the noise term (0–15).
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `datain`  in  16: signed sample from the transmitter (`mod_outdata`).
- `readready`  in  1: `datain` valid (transmitter `writeready`).
- `waitwrite`  out  1: backpressure to the transmitter; while high, no sample is accepted.
- `dataout`  out  16: signed noisy sample to the receiver.
- `writeready`  out  1: `dataout` valid.
- `waitread`  in  1: receiver busy; holds the current output.
- `noise_en`  in  1: 1 adds noise, 0 adds zero.
- `clip_count`  out  16: saturating count of clipped samples.

## Operation

- Internal state:
  - `DELAY` stages, each holding {valid, 16-bit data}.
  - A 16-bit Galois LFSR `lfsr`.
  - `clip_count`.
- Control signals:
  - `advance = ~(writeready & waitread)`.
  - `waitwrite = ~advance` (combinational).
- Accept rule: a sample is accepted on a rising edge where `readready & advance` is true.
- Noise term: `noise = $signed(lfsr) >>> NOISE_SHIFT` when `noise_en`, else 0.
  - Uses the LFSR value before it advances.
- Sum: `sum = sign-extended datain + noise`, 17 bits.
  - If `sum > 32767`, the result is 32767. If `sum < -32768`, the result is -32768. In both cases `clip_count` increments, saturating at 16'hFFFF.
  - Otherwise the result is `sum[15:0]`.
- LFSR update: advances only on an accepted sample.
  - `lfsr <= lfsr[0] ? (lfsr >> 1) ^ 16'hB400 : lfsr >> 1`.
  - It advances even when `noise_en` = 0, so the noise sequence is independent of `noise_en` history.
- Pipeline on an `advance` edge:
  - Stage 0 takes {accepted, result}.
  - Stage i takes stage i-1.
  - A bubble (valid = 0) enters stage 0 when nothing is accepted.
- Pipeline on a stall edge (`advance` = 0): all stages, the LFSR and `clip_count` hold.
- Outputs: `dataout` and `writeready` are driven directly from the last stage. They are registered, with no combinational path from inputs.
- Each output sample is presented exactly once. A sample counts as consumed on the first edge where `writeready & ~waitread`.

## Timing

- Reset (synchronous): all stage valid bits = 0, all stage data = 0, `dataout` = 0, `writeready` = 0, `lfsr = LFSR_SEED`, `clip_count` = 0.
  - `waitwrite` reads 0 after reset, because `writeready` = 0.
- Latency: a sample accepted at edge k appears with `writeready` = 1 in the cycle after edge k+DELAY-1, i.e. DELAY cycles after the accepting edge.
- Throughput: one sample per cycle when unstalled.
- Stall entry and exit:
  - `waitread` = 1 while `writeready` = 1 freezes the whole pipeline on the same edge.
  - `waitwrite` rises combinationally in that cycle.
  - Release resumes on the next edge with no loss or duplication.
- Idle stall: `waitread` = 1 while `writeready` = 0 causes no stall, so bubbles drain.
- Reset mid-operation: all in-flight samples are discarded and `writeready` is 0 on the next cycle. The LFSR reloads the seed.
- Simultaneous accept and stall: accept is blocked, and `readready` must be held by the sender until `waitwrite` = 0.
- Mid-stream `noise_en` change: takes effect on the next accepted sample only.

## Test plan

1. `DELAY`=3, `noise_en`=0, `datain`=12345 with a one-cycle `readready` -> `dataout`=12345 and `writeready`=1, appearing 3 cycles after acceptance. `writeready` stays high one cycle, `clip_count`=0.
2. `noise_en`=1, `NOISE_SHIFT`=4, seed 16'hACE1, `datain`=12345 as the first sample after reset -> `dataout`=11015 (noise -1330). The LFSR then equals 16'hE270.
3. `NOISE_SHIFT`=0, `noise_en`=1, `datain`=-32768 as the first sample -> `dataout`=-32768 and `clip_count`=1. Repeat with `noise_en`=0 -> `clip_count` is unchanged.
4. Stream the samples 1..6 back-to-back, and hold `waitread`=1 for 4 cycles when sample 2 reaches the output -> `waitwrite`=1 during the stall. The output order is 1..6 with no duplicates or drops, and total cycles = 6+3+4.
5. Assert `reset` for one cycle while 3 samples are in flight -> `writeready`=0 for the following DELAY cycles. The next sample gets noise computed from the seed again.
6. Stream the samples 10, 20, 30 with `noise_en`=0 and `waitread` permanently 0 -> `dataout` shows 10, 20, 30 on consecutive cycles.

Source files
------------

// File: rtl/awgn_channel_if.sv
// Sample stream handshake between transmitter, channel and receiver.
// The channel takes the slave modport; the driving side takes master.
interface awgn_channel_if;
  logic [15:0] datain;
  logic        readready;
  logic        waitwrite;
  logic [15:0] dataout;
  logic        writeready;
  logic        waitread;

  modport master (
    output datain, readready, waitread,
    input  waitwrite, dataout, writeready
  );

  modport slave (
    input  datain, readready, waitread,
    output waitwrite, dataout, writeready
  );
endinterface

// File: rtl/awgn_channel.sv
// Synthetic channel: adds shifted LFSR noise to each sample with saturation,
// then delays it through a stallable fixed-depth pipeline.
module awgn_channel #(
  parameter int          DELAY       = 3,
  parameter int          NOISE_SHIFT = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  awgn_channel_if.slave bus,
  input  logic        noise_en,
  output logic [15:0] clip_count
);
  // An all-zero Galois LFSR never leaves zero.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [DELAY-1:0]   stage_valid;
  logic signed [15:0] stage_data [DELAY];
  logic [15:0]        lfsr;

  logic               advance;
  logic               accept;
  logic signed [15:0] noise;
  logic signed [16:0] sum;
  logic signed [15:0] result;
  logic               clip;

  assign advance       = ~(bus.writeready & bus.waitread);
  assign bus.waitwrite = ~advance;
  assign accept        = bus.readready & advance;

  assign noise = noise_en ? ($signed(lfsr) >>> NOISE_SHIFT) : 16'sd0;
  assign sum   = $signed({bus.datain[15], bus.datain}) + $signed({noise[15], noise});

  always_comb begin
    result = sum[15:0];
    clip   = 1'b0;
    // Bits 16 and 15 disagree only when the 17-bit sum is outside 16-bit range.
    if (sum[16] != sum[15]) begin
      clip   = 1'b1;
      result = sum[16] ? 16'sh8000 : 16'sh7FFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid <= '0;
      for (int i = 0; i < DELAY; i++) stage_data[i] <= '0;
      lfsr       <= SEED;
      clip_count <= '0;
    end else if (advance) begin
      stage_valid[0] <= accept;
      stage_data[0]  <= result;
      for (int i = 1; i < DELAY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
      if (accept) begin
        lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
        if (clip && (clip_count != 16'hFFFF)) clip_count <= clip_count + 16'd1;
      end
    end
  end

  assign bus.dataout    = stage_data[DELAY-1];
  assign bus.writeready = stage_valid[DELAY-1];
endmodule
